// File: rtl/stream_buf.sv
// -----------------------------------------------------------------------------
// stream_buf
//   WIDTH-bit, DEPTH-entry first-word-fall-through buffer with valid/ready
//   handshakes on both sides. Absorbs up to DEPTH words of backpressure and
//   preserves strict FIFO order.
//
//   Optional feature macro: STREAM_BUF_BYPASS_EN
//     defined   : when the buffer is empty the producer word is presented
//                 combinationally on the output (zero latency); if the
//                 consumer takes it in the same cycle it is never stored.
//     undefined : no combinational input-to-output path, 1-cycle latency.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_data    in   producer data (WIDTH)
//   in_valid   in   producer offers in_data
//   in_ready   out  buffer accepts a word this cycle
//   out_data   out  head-of-buffer data (WIDTH), zero when out_valid=0
//   out_valid  out  out_data is valid
//   out_ready  in   consumer accepts out_data this cycle
//   count      out  words currently stored, 0..DEPTH (CW bits)
// -----------------------------------------------------------------------------
module stream_buf #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CW-1:0]    count
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   // Low during reset and for the edge on which reset releases; keeps
   // in_ready (and the bypass path) off until the first clock after release.
   logic             alive_q;

   logic empty, full, push, pop;

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));

   always_comb begin
      in_ready = alive_q && !full;
      // Pops only ever come from storage; a bypassed word is never stored.
      pop      = !empty && out_ready;
`ifdef STREAM_BUF_BYPASS_EN
      if (empty) begin
         out_valid = alive_q && in_valid;
         out_data  = out_valid ? in_data : '0;
      end else begin
         out_valid = 1'b1;
         out_data  = mem_q[rd_ptr_q];
      end
      // An empty-buffer word taken by the consumer the same cycle is not stored.
      push = in_valid && in_ready && !(empty && out_ready);
`else
      out_valid = !empty;
      out_data  = empty ? '0 : mem_q[rd_ptr_q];
      push      = in_valid && in_ready;
`endif
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         alive_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         alive_q  <= 1'b1;
      end
   end

   // Storage needs no reset: entries are only visible once written.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

   assign count = count_q;

endmodule

// File: tb/tb_stream_buf.sv
module tb_stream_buf;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = $clog2(DEPTH + 1);
`ifdef STREAM_BUF_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic             clk;
   logic             rst_n;
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic [CW-1:0]    count;

   stream_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned     nvec = 0;
   int unsigned     nerr = 0;
   logic [WIDTH-1:0] sb[$];    // scoreboard: words stored in the buffer, in order
   bit              alive = 1'b0;
   int unsigned     max_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, check outputs at the negedge against the
   // scoreboard, then apply the handshakes to the model after the rising edge.
   task automatic cyc(input logic v, input logic [WIDTH-1:0] d, input logic r);
      bit               exp_rdy, exp_ov, push, pop;
      logic [WIDTH-1:0] exp_od;
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      @(negedge clk);
      exp_rdy = alive && (sb.size() != DEPTH);
      if (sb.size() != 0) begin
         exp_ov = 1'b1;
         exp_od = sb[0];
      end else begin
         exp_ov = BYP && alive && v;
         exp_od = exp_ov ? d : '0;
      end
      chk("count",     32'(count),     32'(sb.size()));
      chk("in_ready",  32'(in_ready),  32'(exp_rdy));
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      chk("out_data",  32'(out_data),  32'(exp_od));
      push = v && exp_rdy && !(BYP && sb.size() == 0 && r);
      pop  = (sb.size() != 0) && r;
      @(posedge clk);
      #1;
      if (!rst_n) begin
         sb.delete();
         alive = 1'b0;
      end else begin
         alive = 1'b1;
         if (pop)  void'(sb.pop_front());
         if (push) sb.push_back(d);
         if (sb.size() > max_cnt) max_cnt = sb.size();
      end
   endtask

   task automatic drain();
      for (int i = 0; i < DEPTH + 2; i++) cyc(1'b0, '0, 1'b1);
   endtask

   task automatic async_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_count",     32'(count),     32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data",  32'(out_data),  32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd0);
      sb.delete();
      alive = 1'b0;
      cyc(1'b1, 8'hEE, 1'b1);    // held in reset across an edge
      rst_n = 1'b1;
      cyc(1'b0, '0, 1'b0);       // release edge: in_ready still 0
      cyc(1'b0, '0, 1'b0);       // in_ready now 1
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      #1;
      chk("init_count",     32'(count),     32'd0);
      chk("init_out_valid", 32'(out_valid), 32'd0);
      chk("init_in_ready",  32'(in_ready),  32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      cyc(1'b0, '0, 1'b0);
      cyc(1'b0, '0, 1'b0);

      // Fill to DEPTH, fifth word refused, then drain in order.
      cyc(1'b1, 8'h11, 1'b0);
      cyc(1'b1, 8'h22, 1'b0);
      cyc(1'b1, 8'h33, 1'b0);
      cyc(1'b1, 8'h44, 1'b0);
      cyc(1'b1, 8'h55, 1'b0);
      cyc(1'b1, 8'h55, 1'b0);
      for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1);
      cyc(1'b0, '0, 1'b0);

      // Full with push+pop on the same edge: only the pop happens.
      cyc(1'b1, 8'h11, 1'b0);
      cyc(1'b1, 8'h22, 1'b0);
      cyc(1'b1, 8'h33, 1'b0);
      cyc(1'b1, 8'h44, 1'b0);
      cyc(1'b1, 8'h55, 1'b1);
      cyc(1'b1, 8'h55, 1'b0);
      drain();

      // Streaming at count=2, push and pop every cycle.
      cyc(1'b1, 8'hE0, 1'b0);
      cyc(1'b1, 8'hE1, 1'b0);
      for (int i = 0; i < 20; i++) cyc(1'b1, 8'(i), 1'b1);
      drain();

      // Pointer wrap: rounds of 3 pushes then 3 pops.
      for (int k = 0; k < 10; k++) begin
         for (int j = 0; j < 3; j++) cyc(1'b1, 8'($urandom), 1'b0);
         for (int j = 0; j < 3; j++) cyc(1'b0, '0, 1'b1);
      end
      chk("max_count", 32'(max_cnt <= DEPTH), 32'd1);

      // Random traffic.
      for (int i = 0; i < 80; i++)
         cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
      drain();

      // Reset mid-burst with three words stored.
      cyc(1'b1, 8'hA1, 1'b0);
      cyc(1'b1, 8'hA2, 1'b0);
      cyc(1'b1, 8'hA3, 1'b0);
      chk("pre_rst_count", 32'(count), 32'd3);
      async_reset();

      // Empty buffer, word offered with consumer ready.
      cyc(1'b1, 8'hA5, 1'b1);
      cyc(1'b0, '0, 1'b1);
      cyc(1'b0, '0, 1'b1);
      // Empty buffer, word offered with consumer stalled.
      cyc(1'b1, 8'h5A, 1'b0);
      cyc(1'b0, '0, 1'b1);
      cyc(1'b0, '0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
